// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI frame writer, the ping-pong RAM and its reader.
// Holds the default frame geometry, the writer state encoding and a small
// saturating-increment helper for 8-bit counters.
package spi_ram_pkg;

    localparam int FRAME_LEN_DEF = 64;   // bytes per bank
    localparam int ADDR_W_DEF    = 7;    // write-address width
    localparam int DATA_W_DEF    = 8;    // byte width

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        FINISH = 2'd2,
        WAIT   = 2'd3
    } wr_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_frame_writer_if.sv
// RAM port-A write bundle between the frame writer (master) and the
// ping-pong RAM (slave).
//   readya  : bank available for writing (RAM -> writer)
//   addra   : write address
//   wea     : one-cycle write strobe per byte
//   dina    : write data
//   finisha : one-cycle pulse, bank full and handed over
interface spi_frame_writer_if
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              readya;
    logic [ADDR_W-1:0] addra;
    logic              wea;
    logic [DATA_W-1:0] dina;
    logic              finisha;

    modport master (input readya, output addra, output wea, output dina, output finisha);
    modport slave  (output readya, input addra, input wea, input dina, input finisha);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one edge-detected input plus a bundle of
// level-only inputs, all sampled into the clk domain.
//   clk, rst  : system clock, synchronous active-high reset
//   edge_in   : asynchronous input whose rising edge is wanted
//   lvl_in    : asynchronous inputs needing only synchronization
//   edge_rise : one-cycle pulse on a synchronized rising edge of edge_in
//   lvl_q     : synchronized lvl_in
module spi_sync_edge #(
    parameter int              LVL_W   = 2,
    parameter logic [LVL_W-1:0] LVL_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             edge_in,
    input  logic [LVL_W-1:0] lvl_in,
    output logic             edge_rise,
    output logic [LVL_W-1:0] lvl_q
);
    logic             edge_meta_reg, edge_sync_reg, edge_prev_reg;
    logic [LVL_W-1:0] lvl_meta_reg, lvl_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_meta_reg <= 1'b0;
            edge_sync_reg <= 1'b0;
            edge_prev_reg <= 1'b0;
            lvl_meta_reg  <= LVL_RST;
            lvl_sync_reg  <= LVL_RST;
        end else begin
            edge_meta_reg <= edge_in;
            edge_sync_reg <= edge_meta_reg;
            edge_prev_reg <= edge_sync_reg;
            lvl_meta_reg  <= lvl_in;
            lvl_sync_reg  <= lvl_meta_reg;
        end
    end

    assign edge_rise = edge_sync_reg & ~edge_prev_reg;
    assign lvl_q     = lvl_sync_reg;
endmodule

// File: rtl/spi_frame_writer.sv
// SPI (mode 0, MSB first) byte receiver that writes bytes into one bank of a
// ping-pong RAM and hands the bank over once FRAME_LEN bytes are written.
// Bytes arriving while no bank is available are dropped and counted.
//   clk, rst         : system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi : asynchronous SPI slave inputs (sclk <= clk/4)
//   ovf_clr          : pulse clearing ovf and drop_cnt
//   ram              : RAM port-A write bundle (master side)
//   ovf              : sticky byte-dropped flag
//   drop_cnt         : saturating dropped-byte count
module spi_frame_writer
    import spi_ram_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    input  logic                ovf_clr,
    spi_frame_writer_if.master  ram,
    output logic                ovf,
    output logic [7:0]          drop_cnt
);
    localparam int BIT_W = $clog2(DATA_W);

    logic [1:0] lvl_q;
    logic       sclk_rise, cs_n_s, mosi_s;

    // lvl bit 0 = cs_n (idles high), bit 1 = mosi
    spi_sync_edge #(.LVL_W(2), .LVL_RST(2'b01)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .edge_in   (spi_sclk),
        .lvl_in    ({spi_mosi, spi_cs_n}),
        .edge_rise (sclk_rise),
        .lvl_q     (lvl_q)
    );
    assign cs_n_s = lvl_q[0];
    assign mosi_s = lvl_q[1];

    // Serial-to-parallel
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              bit_strobe, byte_done;
    logic [DATA_W-1:0] byte_val;

    assign bit_strobe = sclk_rise & ~cs_n_s;
    assign byte_done  = bit_strobe && (bit_cnt_reg == BIT_W'(DATA_W - 1));
    assign byte_val   = {shift_reg[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst || cs_n_s) begin
            // Deselect abandons any partial byte; the write address is untouched.
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (bit_strobe) begin
            shift_reg   <= byte_val;
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
    end

    // Write-side state machine
    wr_state_t         state_reg;
    logic [ADDR_W-1:0] addra_reg;
    logic [DATA_W-1:0] dina_reg;
    logic              wea_reg, finisha_reg, ovf_reg;
    logic [7:0]        drop_cnt_reg;
    logic              byte_accept, byte_drop;

    // A byte landing in IDLE/WAIT together with readya is still accepted,
    // since the bank is already ours for that cycle.
    always_comb begin
        byte_accept = 1'b0;
        if (byte_done) begin
            case (state_reg)
                RECV:        byte_accept = 1'b1;
                IDLE, WAIT:  byte_accept = ram.readya;
                default:     byte_accept = 1'b0;
            endcase
        end
        byte_drop = byte_done && !byte_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            addra_reg    <= '0;
            dina_reg     <= '0;
            wea_reg      <= 1'b0;
            finisha_reg  <= 1'b0;
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wea_reg     <= 1'b0;
            finisha_reg <= 1'b0;

            if (byte_accept) begin
                wea_reg  <= 1'b1;
                dina_reg <= byte_val;
            end

            case (state_reg)
                IDLE, WAIT: begin
                    if (ram.readya) state_reg <= RECV;
                end
                RECV: begin
                    // Address advances in the cycle the write is presented.
                    if (wea_reg) begin
                        if (addra_reg == ADDR_W'(FRAME_LEN - 1)) begin
                            state_reg   <= FINISH;
                            finisha_reg <= 1'b1;
                        end else begin
                            addra_reg <= addra_reg + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    addra_reg <= '0;
                    state_reg <= WAIT;
                end
                default: state_reg <= IDLE;
            endcase

            // A drop in the same cycle as a clear wins and counts as the first drop.
            if (byte_drop) begin
                ovf_reg      <= 1'b1;
                drop_cnt_reg <= ovf_clr ? 8'd1 : sat_inc8(drop_cnt_reg);
            end else if (ovf_clr) begin
                ovf_reg      <= 1'b0;
                drop_cnt_reg <= '0;
            end
        end
    end

    assign ram.addra   = addra_reg;
    assign ram.wea     = wea_reg;
    assign ram.dina    = dina_reg;
    assign ram.finisha = finisha_reg;
    assign ovf         = ovf_reg;
    assign drop_cnt    = drop_cnt_reg;
endmodule

// File: doc/spi_frame_writer.md
SPI_FRAME_WRITER -- requirements
Module: spi_frame_writer

Interface
REQ-001 Parameter: FRAME_LEN, 64, bytes per ping-pong bank frame (2..128).
REQ-002 Parameter: ADDR_W, 7, write-address width.
REQ-003 Parameter: DATA_W, 8, byte width.
REQ-004 Port: clk  in  1  single system clock; the block SHALL use no other clock.
REQ-005 Port: rst  in  1  reset; synchronous and active-high.
REQ-006 Port: spi_sclk  in  1  SPI clock, asynchronous to clk, mode 0.
REQ-007 Port: spi_cs_n  in  1  SPI chip select, active-low, asynchronous.
REQ-008 Port: spi_mosi  in  1  SPI serial data, MSB first, asynchronous.
REQ-009 Port: readya  in  1  ping-pong RAM write-side bank available.
REQ-010 Port: ovf_clr  in  1  one-cycle pulse that clears ovf and drop_cnt.
REQ-011 Port: addra  out  ADDR_W  RAM port-A write address.
REQ-012 Port: wea  out  1  RAM port-A write enable, one-cycle pulse per byte.
REQ-013 Port: dina  out  DATA_W  RAM port-A write data.
REQ-014 Port: finisha  out  1  one-cycle pulse: current bank is full and handed over.
REQ-015 Port: ovf  out  1  sticky flag: at least one byte dropped.
REQ-016 Port: drop_cnt  out  8  dropped-byte count, saturating at 255.

Function
REQ-017 spi_sclk, spi_cs_n and spi_mosi SHALL each pass a 2-flop synchronizer; sclk rising edge is detected from the synchronized signal with one extra register; spi_sclk frequency SHALL be at most clk/4.
REQ-018 On each detected sclk rise with synchronized cs_n=0, the synchronized mosi SHALL shift into an 8-bit shift register and a 3-bit bit counter SHALL increment.
REQ-019 Synchronized cs_n=1 SHALL clear the bit counter and discard any partial byte; the byte address SHALL NOT change.
REQ-020 Byte-complete event SHALL occur on the cycle the 8th bit is shifted in; wea SHALL assert exactly one cycle later with dina = assembled byte and addra = current address.
REQ-021 States: IDLE, RECV, FINISH, WAIT; reset enters IDLE.
REQ-022 IDLE/WAIT: readya=1 -> RECV next cycle; a byte completing in the same cycle as readya=1 SHALL be written (not dropped).
REQ-023 RECV: each byte written at addra, then addra increments; write at addra=FRAME_LEN-1 -> FINISH next cycle.
REQ-024 FINISH: finisha=1 for exactly one cycle, addra <- 0, -> WAIT.
REQ-025 A byte completing in IDLE/WAIT with readya=0, or in FINISH, SHALL be dropped: no wea, ovf <- 1, drop_cnt increments (saturating).
REQ-026 ovf_clr=1 SHALL clear ovf and drop_cnt next cycle; a simultaneous drop SHALL take priority (ovf=1, drop_cnt=1).
REQ-027 wea and finisha SHALL never assert in the same cycle.

Reset
REQ-028 rst=1 SHALL force: state IDLE, addra=0, wea=0, dina=0, finisha=0, ovf=0, drop_cnt=0, shift register and bit counter 0, synchronizers to idle (sclk=0, cs_n=1, mosi=0).
REQ-029 Reset mid-frame SHALL discard the partial frame with no finisha pulse; the next frame restarts at addra=0.

Structure
REQ-030 Package spi_ram_pkg SHALL hold the FRAME_LEN/ADDR_W/DATA_W defaults and the state encoding, shared with the ping-pong RAM and its reader.
REQ-031 Sub-module spi_sync_edge (2-flop synchronizer plus rising-edge detector) SHALL be instantiated for spi_sclk; cs_n and mosi use its synchronizer path only.

Verification
REQ-032 readya=1, send 64 bytes 0x00..0x3F -> 64 wea pulses, addra 0..63, dina=addra, one finisha after the last write, addra=0.
REQ-033 After frame 1, readya=0, send 3 bytes -> no wea, ovf=1, drop_cnt=3; ovf_clr pulse -> ovf=0, drop_cnt=0.
REQ-034 readya=1, send 4 bits then cs_n high, then byte 0xA5 -> single wea, dina=0xA5, addra=0.
REQ-035 readya rises in the same cycle byte 0x5A completes in WAIT -> wea next cycle with dina=0x5A, drop_cnt unchanged.
REQ-036 rst pulsed after 10 bytes -> all outputs 0, no finisha; next 64 bytes fill addra 0..63, then finisha.
REQ-037 Drop 300 bytes -> drop_cnt=255, ovf=1.
